cas_fsk_modulator: RTL
======================

CAS_FSK_MODULATOR -- requirements
Module: cas_fsk_modulator

Interface
REQ-001 SHALL have parameter ZERO_HALF, default 2237; half-period of a '0' tone, in ce ticks (1200 Hz at 5.37 MHz).
REQ-002 SHALL have parameter ONE_HALF, default 1119; half-period of a '1' tone, in ce ticks (2400 Hz).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4; byte FIFO entries, a power of two.
REQ-004 SHALL have one clock and an asynchronous active-low reset; no other clock or reset inputs.
REQ-005 SHALL have port clk_sys, input, 1, system clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port ce, input, 1, timing tick; all tone timing counts ce-high cycles only.
REQ-008 SHALL have port enable, input, 1, motor/play; low freezes waveform generation.
REQ-009 SHALL have port leader_req, input, 1, single-cycle pulse requesting a leader tone.
REQ-010 SHALL have port leader_len, input, 16, number of '1' bits in the leader; sampled with leader_req.
REQ-011 SHALL have port byte_i, input, 8, byte to transmit.
REQ-012 SHALL have port byte_valid, input, 1, byte_i valid.
REQ-013 SHALL have port byte_ready, output, 1, FIFO can accept a byte.
REQ-014 SHALL have port tape_o, output, 1, registered FSK tape level to the console tape input.
REQ-015 SHALL have port busy, output, 1, high when not IDLE, FIFO non-empty, or leader pending.

Function
REQ-016 A byte SHALL be written on a clk_sys edge with byte_valid & byte_ready, independent of ce and enable.
REQ-017 byte_ready SHALL equal FIFO-not-full; a write while full SHALL be impossible; a pop and a write in the same cycle SHALL both take effect.
REQ-018 leader_req SHALL set a pending flag and latch leader_len; a second request while pending SHALL overwrite the length; leader_len=0 SHALL clear the flag and emit nothing.
REQ-019 The FSM SHALL have states IDLE, LEADER, START, DATA, STOP; transitions occur only on edges with ce=1 and enable=1.
REQ-020 From IDLE: a pending leader takes priority and goes to LEADER; otherwise a non-empty FIFO pops one byte and goes to START; otherwise stay in IDLE.
REQ-021 A '0' bit SHALL be one cycle: tape_o high ZERO_HALF ticks, then low ZERO_HALF ticks.
REQ-022 A '1' bit SHALL be two cycles: high ONE_HALF, low ONE_HALF, repeated.
REQ-023 Frame SHALL be START = one '0', DATA = 8 bits LSB first, STOP = two '1'; then IDLE is re-evaluated with no gap tick.
REQ-024 LEADER SHALL emit leader_len '1' bits, clear the pending flag, then return to IDLE evaluation.
REQ-025 Latency: with ce=enable=1 continuously in IDLE, tape_o SHALL rise on the second clk_sys edge after the accepting edge.
REQ-026 When enable=0, the state, bit, tick counters and tape_o SHALL hold; FIFO writes continue.
REQ-027 In IDLE, tape_o SHALL be 0.
REQ-028 The bit index SHALL be a 3-bit counter and the tick counter SHALL be sized to max(ZERO_HALF, ONE_HALF); no wrap beyond the programmed value.

Reset
REQ-029 On reset_n low, the block SHALL immediately force: FSM=IDLE, FIFO empty, leader flag clear, all counters 0, tape_o=0, busy=0, and byte_ready=1 (asynchronous, mid-frame included).
REQ-030 After reset_n deasserts, the first write SHALL be accepted on the next edge.

Verification (ZERO_HALF=4, ONE_HALF=2, ce=1, enable=1 unless noted)
REQ-031 Release reset -> tape_o=0, busy=0, byte_ready=1.
REQ-032 Write 0x01 -> sequence H4L4 (start), H2L2H2L2 (bit0), 7x H4L4, 2x H2L2H2L2 (stop); 88 cycles; then busy=0, tape_o=0.
REQ-033 Write 5 bytes back-to-back while enable=0 -> 4 accepted and byte_ready=0; raise enable -> byte_ready=1 one edge after the first pop.
REQ-034 leader_req with leader_len=3, then write 0xFF -> 24 cycles of '1' tone precede the start bit.
REQ-035 Drop enable for 10 cycles mid-DATA -> waveform pauses, then resumes; frame is 98 cycles.
REQ-036 Assert reset_n mid-frame with 2 bytes queued -> tape_o=0 the same cycle; after release busy=0 and no further output.

Source files
------------

// File: rtl/cas_fsk_modulator.sv
// Purpose: serialises queued bytes (and optional leader tones) into a cassette FSK tape level.
// Latency: tape_o rises on the second clk_sys edge after a byte is accepted by an idle, running modulator.
// Backpressure: byte_ready drops while the byte FIFO is full; enable=0 freezes the waveform, FIFO writes continue.
module cas_fsk_modulator #(
  parameter int ZERO_HALF  = 2237,
  parameter int ONE_HALF   = 1119,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        enable,
  input  logic        leader_req,
  input  logic [15:0] leader_len,
  input  logic [7:0]  byte_i,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        tape_o,
  output logic        busy
);

  localparam int MAX_HALF = (ZERO_HALF > ONE_HALF) ? ZERO_HALF : ONE_HALF;
  localparam int TW = $clog2(MAX_HALF + 1);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] ZERO_LAST = TW'(ZERO_HALF - 1);
  localparam logic [TW-1:0] ONE_LAST  = TW'(ONE_HALF - 1);

  typedef enum logic [2:0] {IDLE, LEADER, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            push, pop, tick;
  logic            pend_q, leader_end;
  logic [15:0]     pend_len_q, lcnt_q;
  logic [TW-1:0]   tick_q, half_last;
  logic            phase_q, rep_q, bit_val, bit_done, tape_q, tape_d;
  logic [2:0]      bit_q;
  logic [7:0]      data_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign tick   = ce && enable;
  assign push   = byte_valid && byte_ready;
  assign tape_o = tape_q;

  // FIFO pointers and occupancy; a pop and a push in one cycle both take effect
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; emptiness comes from the pointers, so the array needs no reset
  always_ff @(posedge clk_sys) begin
    if (push) mem_q[wr_ptr_q] <= byte_i;
  end

  // Leader request latch; a new request overwrites, length 0 cancels
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pend_q     <= 1'b0;
      pend_len_q <= '0;
    end else if (leader_req) begin
      pend_q     <= (leader_len != 16'd0);
      pend_len_q <= leader_len;
    end else if (leader_end) begin
      pend_q <= 1'b0;
    end
  end

  // Current bit value and the end of its last half-period
  always_comb begin
    case (state_q)
      START:   bit_val = 1'b0;
      DATA:    bit_val = data_q[bit_q];
      default: bit_val = 1'b1;
    endcase
    half_last = bit_val ? ONE_LAST : ZERO_LAST;
    bit_done  = (tick_q == half_last) && phase_q && (rep_q || !bit_val);
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state; frame/leader ends re-run the IDLE decision without a gap tick
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    leader_end = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (pend_q) begin
            state_d = LEADER;
          end else if (count_q != '0) begin
            state_d = START;
            pop     = 1'b1;
          end
        end
        LEADER: begin
          if (bit_done && lcnt_q == 16'd1) begin
            leader_end = 1'b1;
            if (count_q != '0) begin
              state_d = START;
              pop     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        START: if (bit_done) state_d = DATA;
        DATA:  if (bit_done && bit_q == 3'd7) state_d = STOP;
        STOP: begin
          if (bit_done && bit_q == 3'd1) begin
            if (pend_q) begin
              state_d = LEADER;
            end else if (count_q != '0) begin
              state_d = START;
              pop     = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; tape follows the registered phase one tick later
  always_comb begin
    byte_ready = (count_q != CW'(FIFO_DEPTH));
    busy       = (state_q != IDLE) || (count_q != '0) || pend_q;
    tape_d     = (state_q != IDLE) && !phase_q;
  end

  // Tone timing, bit/leader counters and tape register; everything holds unless ce and enable
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tick_q  <= '0;
      phase_q <= 1'b0;
      rep_q   <= 1'b0;
      bit_q   <= '0;
      lcnt_q  <= '0;
      data_q  <= '0;
      tape_q  <= 1'b0;
    end else if (tick) begin
      tape_q <= tape_d;
      if (state_q == IDLE || bit_done) begin
        tick_q  <= '0;
        phase_q <= 1'b0;
        rep_q   <= 1'b0;
      end else if (tick_q == half_last) begin
        tick_q  <= '0;
        phase_q <= ~phase_q;
        if (phase_q) rep_q <= 1'b1;
      end else begin
        tick_q <= tick_q + TW'(1);
      end
      if (state_d != state_q) bit_q <= '0;
      else if (bit_done)      bit_q <= bit_q + 3'd1;
      if (state_d == LEADER && state_q != LEADER)
        lcnt_q <= pend_len_q;
      else if (state_q == LEADER && bit_done)
        lcnt_q <= lcnt_q - 16'd1;
      if (pop) data_q <= mem_q[rd_ptr_q];
    end
  end

endmodule
